// File: rtl/vpg_window_gen_if.sv
// vpg_window_gen_if: pixel read bus between the timing generator (master) and its pixel source (slave).
interface vpg_window_gen_if;
    logic        rd_req;
    logic [23:0] rd_data;
    logic        rd_valid;
    modport master (output rd_req, input rd_data, input rd_valid);
    modport slave  (input rd_req, output rd_data, output rd_valid);
endinterface

// File: rtl/vpg_window_gen.sv
// vpg_window_gen: video timing generator overlaying a fetched image window on a selectable background.
// Define VPG_UNDERFLOW_DET_EN to flag window pixels that arrive without rd_valid.
module vpg_window_gen #(
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int WIN_W    = 256,
    parameter int WIN_H    = 256,
    parameter int RD_LEAD  = 2,
    parameter int CNT_W    = 12
) (
    input  logic             vpg_pclk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] win_x,
    input  logic [CNT_W-1:0] win_y,
    input  logic [1:0]       bg_mode,
    input  logic [23:0]      bg_color,
    vpg_window_gen_if.master rd,
    output logic             vpg_de,
    output logic             vpg_hs,
    output logic             vpg_vs,
    output logic [23:0]      rgb,
    output logic             frame_start,
    output logic             underflow
);
    typedef logic [CNT_W:0] ext_t;
    localparam ext_t L_HSYNC = ext_t'(H_SYNC);
    localparam ext_t L_VSYNC = ext_t'(V_SYNC);
    localparam ext_t L_HS0   = ext_t'(H_SYNC + H_BP);
    localparam ext_t L_HE    = ext_t'(H_SYNC + H_BP + H_ACTIVE);
    localparam ext_t L_VS0   = ext_t'(V_SYNC + V_BP);
    localparam ext_t L_VE    = ext_t'(V_SYNC + V_BP + V_ACTIVE);
    localparam ext_t L_WW    = ext_t'(WIN_W);
    localparam ext_t L_WH    = ext_t'(WIN_H);
    localparam ext_t L_LEAD  = ext_t'(RD_LEAD);
    localparam logic [CNT_W-1:0] L_HLAST = CNT_W'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
    localparam logic [CNT_W-1:0] L_VLAST = CNT_W'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic [CNT_W-1:0] r_cnt_h, r_cnt_v, r_win_x, r_win_y;
    logic [1:0]       r_bg_mode;
    ext_t             w_h, w_v, w_hl, w_px, w_pxl, w_py, w_x, w_y;
    logic             w_h_act, w_hl_act, w_v_act, w_win_y, w_win, w_win_l, w_frame_end;
    logic [23:0]      w_bg, w_pix;

    // Window bounds are evaluated one bit wider than the counters so x+WIN_W never wraps.
    always_comb begin
        w_h         = {1'b0, r_cnt_h};
        w_v         = {1'b0, r_cnt_v};
        w_hl        = w_h + L_LEAD;
        w_x         = {1'b0, r_win_x};
        w_y         = {1'b0, r_win_y};
        w_px        = w_h - L_HS0;
        w_pxl       = w_hl - L_HS0;
        w_py        = w_v - L_VS0;
        w_h_act     = w_h >= L_HS0 && w_h < L_HE;
        w_hl_act    = w_hl >= L_HS0 && w_hl < L_HE;
        w_v_act     = w_v >= L_VS0 && w_v < L_VE;
        w_win_y     = w_v_act && w_py >= w_y && w_py < w_y + L_WH;
        w_win       = w_h_act && w_win_y && w_px >= w_x && w_px < w_x + L_WW;
        w_win_l     = w_hl_act && w_win_y && w_pxl >= w_x && w_pxl < w_x + L_WW;
        w_frame_end = r_cnt_h == L_HLAST && r_cnt_v == L_VLAST;
        w_bg        = r_bg_mode == 2'd0 ? 24'h000000 :
                      r_bg_mode == 2'd1 ? BARS[w_px[7:5]] :
                      r_bg_mode == 2'd2 ? {24{w_px[4] ^ w_py[4]}} : bg_color;
    end

`ifdef VPG_UNDERFLOW_DET_EN
    logic r_underflow;
    always_ff @(posedge vpg_pclk) begin
        if (!rst_n)
            r_underflow <= 1'b0;
        else if (w_win && !rd.rd_valid)
            r_underflow <= 1'b1;
    end
    assign underflow = r_underflow;
    assign w_pix     = rd.rd_valid ? rd.rd_data : 24'hFF00FF;
`else
    logic w_unused_valid;
    assign w_unused_valid = rd.rd_valid;
    assign underflow      = 1'b0;
    assign w_pix          = rd.rd_data;
`endif

    always_ff @(posedge vpg_pclk) begin
        if (!rst_n) begin
            r_cnt_h     <= '0;
            r_cnt_v     <= '0;
            r_win_x     <= win_x;
            r_win_y     <= win_y;
            r_bg_mode   <= bg_mode;
            vpg_hs      <= ~HS_POL;
            vpg_vs      <= ~VS_POL;
            vpg_de      <= 1'b0;
            rd.rd_req   <= 1'b0;
            frame_start <= 1'b0;
            rgb         <= '0;
        end else begin
            r_cnt_h <= r_cnt_h == L_HLAST ? '0 : r_cnt_h + CNT_W'(1);
            if (r_cnt_h == L_HLAST)
                r_cnt_v <= r_cnt_v == L_VLAST ? '0 : r_cnt_v + CNT_W'(1);
            if (w_frame_end) begin
                r_win_x   <= win_x;
                r_win_y   <= win_y;
                r_bg_mode <= bg_mode;
            end
            vpg_hs      <= w_h < L_HSYNC ? HS_POL : ~HS_POL;
            vpg_vs      <= w_v < L_VSYNC ? VS_POL : ~VS_POL;
            vpg_de      <= w_h_act && w_v_act;
            rd.rd_req   <= w_win_l;
            frame_start <= r_cnt_h == '0 && r_cnt_v == '0;
            rgb         <= !(w_h_act && w_v_act) ? 24'h000000 : w_win ? w_pix : w_bg;
        end
    end
endmodule

// File: tb/tb_vpg_window_gen.sv
// tb_vpg_window_gen: reduced-timing bench with a frame-level reference model and a ramp pixel source.
module tb_vpg_window_gen;
    localparam int HSY = 8, HBP = 8, HA = 300, HFP = 4;
    localparam int VSY = 2, VBP = 2, VA = 12, VFP = 2;
    localparam int WW = 16, WH = 4, LEAD = 2;
    localparam int HT = HSY + HBP + HA + HFP, VT = VSY + VBP + VA + VFP, FR = HT * VT;
    localparam int HS0 = HSY + HBP, VS0 = VSY + VBP;
    localparam int INJ = 150;
`ifdef VPG_UNDERFLOW_DET_EN
    localparam bit UF_EN = 1'b1;
`else
    localparam bit UF_EN = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [11:0] win_x, win_y;
    logic [1:0]  bg_mode;
    logic [23:0] bg_color, rgb;
    logic        vpg_de, vpg_hs, vpg_vs, frame_start, underflow;

    vpg_window_gen_if rd_if();

    vpg_window_gen #(
        .H_SYNC(HSY), .H_BP(HBP), .H_ACTIVE(HA), .H_FP(HFP),
        .V_SYNC(VSY), .V_BP(VBP), .V_ACTIVE(VA), .V_FP(VFP),
        .HS_POL(1'b0), .VS_POL(1'b0), .WIN_W(WW), .WIN_H(WH), .RD_LEAD(LEAD), .CNT_W(12)
    ) u_dut (
        .vpg_pclk(clk), .rst_n(rst_n), .win_x(win_x), .win_y(win_y),
        .bg_mode(bg_mode), .bg_color(bg_color), .rd(rd_if),
        .vpg_de(vpg_de), .vpg_hs(vpg_hs), .vpg_vs(vpg_vs), .rgb(rgb),
        .frame_start(frame_start), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;

    task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] ramp(input int n);
        return {8'hC3, 16'(n * 7 + 1)};
    endfunction

    function automatic bit act(input int h, input int v);
        return h >= HS0 && h < HS0 + HA && v >= VS0 && v < VS0 + VA;
    endfunction

    function automatic bit inwin(input int h, input int v, input int x, input int y);
        return act(h, v) && h - HS0 >= x && h - HS0 < x + WW && v - VS0 >= y && v - VS0 < y + WH;
    endfunction

    function automatic logic [23:0] bg(input int mode, input int px, input int py, input logic [23:0] col);
        logic [23:0] bar;
        case ((px / 32) % 8)
            0: bar = 24'hFFFFFF;
            1: bar = 24'hFFFF00;
            2: bar = 24'h00FFFF;
            3: bar = 24'h00FF00;
            4: bar = 24'hFF00FF;
            5: bar = 24'hFF0000;
            6: bar = 24'h0000FF;
            default: bar = 24'h000000;
        endcase
        if (mode == 0) return 24'h000000;
        if (mode == 1) return bar;
        if (mode == 2) return (((px / 16) % 2) != ((py / 16) % 2)) ? 24'hFFFFFF : 24'h000000;
        return col;
    endfunction

    // Pixel source: answers each rd_req with the next ramp value one clock later.
    bit pend = 1'b0;
    int n_srv = 0;
    task automatic respond();
        if (pend) begin
            rd_if.rd_data  = ramp(n_srv);
            rd_if.rd_valid = (n_srv != INJ);
            n_srv++;
        end else begin
            rd_if.rd_data  = 24'h5A5A5A;
            rd_if.rd_valid = 1'b0;
        end
        pend = rd_if.rd_req;
    endtask

    initial begin
        win_x = 12'd0; win_y = 12'd0; bg_mode = 2'd1; bg_color = 24'h3A5C7E;
        rd_if.rd_data = 24'h0; rd_if.rd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 1; c <= FR * 4 + 3000; c++) begin
            @(posedge clk); #1;
            respond();
            if (c == 2000) win_x = 12'd100;
            if (c == FR + 2000) begin win_x = 12'd290; win_y = 12'd10; bg_mode = 2'd2; end
            if (c == 2 * FR + 2000) begin win_x = 12'd192; win_y = 12'd4; bg_mode = 2'd3; end
        end
        rst_n = 1'b0; win_x = 12'd296; win_y = 12'd0; bg_mode = 2'd0;
        repeat (3) begin @(posedge clk); #1; respond(); end
        rst_n = 1'b1;
        repeat (FR + 5) begin @(posedge clk); #1; respond(); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Reference model and single compare process.
    int exp_req [5] = '{64, 64, 20, 64, 16};
    int exp_first [5] = '{1294, 1394, 4784, 2766, 1590};
    initial begin
        logic        cap_rst, cap_valid;
        logic [23:0] cap_color, e_rgb;
        int cap_x, cap_y, cap_mode, sh_x, sh_y, sh_mode;
        int s, p, h, v, px, jwin, nf, de_c, hs_c, vs_c, fs_c, req_c, first_p;
        bit u;
        s = 0; jwin = 0; nf = 0; u = 1'b0;
        sh_x = 0; sh_y = 0; sh_mode = 0;
        de_c = 0; hs_c = 0; vs_c = 0; fs_c = 0; req_c = 0; first_p = -1;
        forever begin
            @(posedge clk);
            cap_rst = rst_n; cap_valid = rd_if.rd_valid; cap_color = bg_color;
            cap_x = int'(win_x); cap_y = int'(win_y); cap_mode = int'(bg_mode);
            @(negedge clk);
            if (!cap_rst) begin
                check("rst_hs", vpg_hs, 1'b1);
                check("rst_vs", vpg_vs, 1'b1);
                check("rst_de", vpg_de, 1'b0);
                check("rst_rgb", rgb, 24'h0);
                check("rst_rd_req", rd_if.rd_req, 1'b0);
                check("rst_frame_start", frame_start, 1'b0);
                check("rst_underflow", underflow, 1'b0);
                s = 0; u = 1'b0;
                sh_x = cap_x; sh_y = cap_y; sh_mode = cap_mode;
            end else begin
                p = s % FR; h = p % HT; v = p / HT;
                if (p == 0) begin
                    de_c = 0; hs_c = 0; vs_c = 0; fs_c = 0; req_c = 0; first_p = -1;
                end
                if (!act(h, v))
                    e_rgb = 24'h0;
                else if (inwin(h, v, sh_x, sh_y)) begin
                    if (UF_EN && !cap_valid) begin
                        e_rgb = 24'hFF00FF;
                        u = 1'b1;
                    end else
                        e_rgb = ramp(jwin);
                    jwin++;
                end else
                    e_rgb = bg(sh_mode, h - HS0, v - VS0, cap_color);
                check("hs", vpg_hs, (h < HSY) ? 1'b0 : 1'b1);
                check("vs", vpg_vs, (v < VSY) ? 1'b0 : 1'b1);
                check("de", vpg_de, act(h, v));
                check("frame_start", frame_start, p == 0);
                check("rd_req", rd_if.rd_req, inwin(h + LEAD, v, sh_x, sh_y));
                check("rgb", rgb, e_rgb);
                check("underflow", underflow, u);
                de_c += int'(vpg_de); fs_c += int'(frame_start); req_c += int'(rd_if.rd_req);
                hs_c += int'(!vpg_hs); vs_c += int'(!vpg_vs);
                if (rd_if.rd_req && first_p < 0) first_p = p;
                if (sh_mode == 1 && v == VS0 + 5 && act(h, v)) begin
                    px = h - HS0;
                    if (px == 0 || px == 31 || px == 256) check("bar_white", rgb, 24'hFFFFFF);
                    if (px == 32 || px == 288) check("bar_yellow", rgb, 24'hFFFF00);
                    if (px == 224 || px == 255) check("bar_black", rgb, 24'h000000);
                end
                if (p == FR - 1) begin
                    sh_x = cap_x; sh_y = cap_y; sh_mode = cap_mode;
                    if (nf < 5) begin
                        check("frame_de_count", 24'(de_c), 24'(3600));
                        check("frame_hs_low", 24'(hs_c), 24'(144));
                        check("frame_vs_low", 24'(vs_c), 24'(640));
                        check("frame_start_count", 24'(fs_c), 24'(1));
                        check("frame_rd_req_count", 24'(req_c), 24'(exp_req[nf]));
                        check("first_rd_req_pos", 24'(first_p), 24'(exp_first[nf]));
                        if (nf == 3) check("underflow_sticky", underflow, UF_EN);
                        if (nf == 4) check("underflow_cleared", underflow, 1'b0);
                    end
                    nf++;
                end
                s++;
            end
        end
    end
endmodule

// File: doc/vpg_window_gen.md
VPG_WINDOW_GEN -- requirements
Module: vpg_window_gen

Interface
REQ-001 SHALL have parameter H_SYNC, default 96, meaning horizontal sync width in pixel clocks.
REQ-002 SHALL have parameters H_BP/H_ACTIVE/H_FP, defaults 48/640/16, meaning back porch, active pixels and front porch.
REQ-003 SHALL have parameters V_SYNC/V_BP/V_ACTIVE/V_FP, defaults 2/33/480/10, meaning the same in lines.
REQ-004 SHALL have parameters HS_POL/VS_POL, default 0/0, meaning the asserted sync level.
REQ-005 SHALL have parameters WIN_W/WIN_H, default 256/256, meaning image window size; RD_LEAD, default 2 (range 1..8), meaning rd_req lead in clocks; CNT_W, default 12, meaning counter width.
REQ-006 SHALL have ports vpg_pclk in 1, the pixel clock, and rst_n in 1, a synchronous active-low reset.
REQ-007 SHALL have ports win_x in CNT_W and win_y in CNT_W, the window top-left in active coordinates.
REQ-008 SHALL have ports bg_mode in 2, the background select, and bg_color in 24, the solid background colour.
REQ-009 SHALL have ports rd_data in 24, the window pixel, and rd_valid in 1, meaning rd_data is valid.
REQ-010 SHALL have ports vpg_de/vpg_hs/vpg_vs out 1 each, the video timing outputs.
REQ-011 SHALL have ports rgb out 24 (RGB888), rd_req out 1 (pixel read request), frame_start out 1 (frame pulse) and underflow out 1 (sticky flag).

Function
REQ-012 SHALL run cnt_h 0..H_TOTAL-1 (H_TOTAL = sum of the H parameters) and cnt_v 0..V_TOTAL-1; cnt_v SHALL step when cnt_h wraps, and both SHALL wrap together at frame end.
REQ-013 SHALL use line order sync, back porch, active, front porch: hs=HS_POL iff cnt_h<H_SYNC; vs=VS_POL iff cnt_v<V_SYNC.
REQ-014 SHALL define px=cnt_h-(H_SYNC+H_BP) and py=cnt_v-(V_SYNC+V_BP); a pixel is active iff 0<=px<H_ACTIVE and 0<=py<V_ACTIVE.
REQ-015 SHALL register all outputs so that they reflect the counter state of the previous clock (latency 1).
REQ-016 SHALL set vpg_de=1 iff active and frame_start=1 for exactly one clock, for counter state (0,0).
REQ-017 SHALL latch win_x, win_y and bg_mode into shadow registers only at frame end (last cnt_h of last line); mid-frame input changes SHALL take effect at the next frame.
REQ-018 SHALL treat a pixel as in-window iff it is active, win_x<=px<win_x+WIN_W and win_y<=py<win_y+WIN_H, with sums computed at CNT_W+1 bits (no wrap); the part of the window beyond the active area SHALL be clipped.
REQ-019 SHALL drive rd_req for the pixel that is RD_LEAD clocks ahead of the current counter state, and only when that pixel is in-window; rd_req pulses per frame SHALL equal the clipped window area.
REQ-020 SHALL require rd_data to be valid RD_LEAD-1 clocks after the corresponding rd_req cycle.
REQ-021 SHALL set rgb for an in-window pixel to rd_data.
REQ-022 SHALL set rgb for a non-window active pixel by bg_mode: 0 gives 000000; 1 gives bars indexed by px[7:5] (white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000); 2 gives FFFFFF if px[4]^py[4] else 000000; 3 gives bg_color.
REQ-023 SHALL set rgb=0 for any non-active pixel.

Reset
REQ-024 SHALL, while rst_n=0 at a clock edge, clear the counters to 0, set vpg_hs=~HS_POL, vpg_vs=~VS_POL, set vpg_de/rd_req/frame_start/underflow=0 and rgb=0, and load shadows from the inputs.
REQ-025 SHALL, on reset asserted mid-line or mid-frame, abort the frame immediately; after release the frame restarts at (0,0), with the first outputs appearing one clock later.

Configuration
REQ-026 SHALL gate underflow detection with macro VPG_UNDERFLOW_DET_EN: when defined, an in-window pixel sampled with rd_valid=0 gives rgb=FF00FF and sets underflow, which stays set until reset.
REQ-027 SHALL, when VPG_UNDERFLOW_DET_EN is undefined, ignore rd_valid, tie underflow to 0 and pass rd_data as the window pixel; the ports SHALL exist in both builds.

Verification
REQ-028 SHALL cover reset release with defaults: hs low 96 of every 800 clocks, vs low 1600 of 420000 clocks, vpg_de high 307200 clocks per frame, frame_start once per 420000 clocks.
REQ-029 SHALL cover win_x=192 and win_y=112 with WIN 256x256 and RD_LEAD=2: 65536 rd_req per frame, the first rd_req 2 clocks before de of px=192 on py=112, and rgb matching the rd_data ramp.
REQ-030 SHALL cover clipping with win_x=500 and win_y=400: exactly 140*80=11200 rd_req per frame, none outside the active area.
REQ-031 SHALL cover a win_x change from 0 to 100 mid-frame: the current frame keeps the window at px=0 and the next frame starts at px=100.
REQ-032 SHALL cover bg_mode=1 with the window off-screen: px 0..31 give FFFFFF, px 32 gives FFFF00, px 224..255 give 000000, and the pattern repeats at px 256.
REQ-033 SHALL cover, with VPG_UNDERFLOW_DET_EN, rd_valid=0 for one window pixel: that rgb is FF00FF, underflow rises and holds until rst_n=0; without the macro, rgb=rd_data and underflow=0.
